// File: rtl/axis_weights_packer_if.sv
// AXI-Stream bundle used on both sides of axis_weights_packer.
// DATA_W sets tdata; tkeep carries one bit per byte of tdata.
interface axis_weights_packer_if #(
  parameter int DATA_W = 8,
  localparam int KEEP_W = (DATA_W + 7) / 8
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_weights_packer.sv
// axis_weights_packer: packs weight words into wide AXI-Stream beats for the
// weight rotator. Each frame is a header beat, config beats and kernel rows;
// its length comes from a config latched at the start of the frame.
// Optional macro WEIGHTS_PACKER_FRAME_CHECK_EN: compare s_axis.tlast with the
// expected last word and raise a sticky err_frame_o on mismatch.
module axis_weights_packer #(
  parameter int WORD_WIDTH         = 8,
  parameter int S_WEIGHTS_WIDTH_HF = 64,
  parameter int CORES              = 2,
  parameter int MEMBERS            = 6,
  parameter int KH_MAX             = 3,
  parameter int IM_CIN_MAX         = 64,
  parameter int BITS_CFG           = 8,
  localparam int WPB       = S_WEIGHTS_WIDTH_HF / WORD_WIDTH,
  localparam int ROW       = CORES * MEMBERS,
  localparam int BITS_K    = $clog2(KH_MAX),
  localparam int BITS_CIN  = $clog2(IM_CIN_MAX),
  localparam int KEEP_W    = S_WEIGHTS_WIDTH_HF / 8,
  localparam int WB        = WORD_WIDTH / 8,
  localparam int TOTAL_MAX = WPB + ((1 << BITS_CFG) + (1 << BITS_K) * (1 << BITS_CIN)) * ROW,
  localparam int TW        = $clog2(TOTAL_MAX + 1),
  localparam int IDXW      = (WPB > 1) ? $clog2(WPB) : 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [BITS_K-1:0]   cfg_k_1_i,
  input  logic [BITS_CIN-1:0] cfg_cin_1_i,
  input  logic [BITS_CFG-1:0] cfg_beats_config_1_i,
  axis_weights_packer_if.slave  s_axis,
  axis_weights_packer_if.master m_axis,
  output logic                busy_o,
  output logic                err_frame_o
);

  typedef enum logic [1:0] {IDLE, CALC, PACK, DRAIN} state_t;

  state_t                  state_q;
  logic [BITS_K-1:0]       k_1_q;
  logic [BITS_CIN-1:0]     cin_1_q;
  logic [BITS_CFG-1:0]     bc_1_q;
  logic [TW-1:0]           rem_q;
  logic [IDXW-1:0]         idx_q;
  logic [WORD_WIDTH-1:0]   buf_q [WPB];
  logic                    m_tvalid_q;
  logic [S_WEIGHTS_WIDTH_HF-1:0] m_tdata_q;
  logic [KEEP_W-1:0]       m_tkeep_q;
  logic                    m_tlast_q;

  logic                    s_hs;
  logic                    out_hs;
  logic                    last_word;
  logic                    beat_done;
  logic [S_WEIGHTS_WIDTH_HF-1:0] beat_data;
  logic [KEEP_W-1:0]       beat_keep;

  // Words in a frame: one header beat, then config beats and k*cin kernel rows.
  function automatic logic [TW-1:0] frame_total(input logic [BITS_K-1:0]   k_1,
                                                input logic [BITS_CIN-1:0] cin_1,
                                                input logic [BITS_CFG-1:0] bc_1);
    logic [TW-1:0] rows;
    rows = (TW'(k_1) + TW'(1)) * (TW'(cin_1) + TW'(1));
    return TW'(WPB) + (TW'(bc_1) + TW'(1) + rows) * TW'(ROW);
  endfunction

  assign s_hs      = s_axis.tvalid & s_axis.tready;
  assign out_hs    = m_tvalid_q & m_axis.tready;
  assign last_word = (rem_q == TW'(1));
  assign beat_done = s_hs & ((idx_q == IDXW'(WPB - 1)) | last_word);

  assign cfg_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign s_axis.tready = (state_q == PACK) & (~m_tvalid_q | m_axis.tready);

  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tkeep  = m_tkeep_q;
  assign m_axis.tlast  = m_tlast_q;

  // Beat image: stored slots below idx, the incoming word at idx, zeros above.
  always_comb begin
    beat_data = '0;
    beat_keep = '0;
    for (int i = 0; i < WPB; i++) begin
      if (IDXW'(i) < idx_q) begin
        beat_data[i*WORD_WIDTH +: WORD_WIDTH] = buf_q[i];
        beat_keep[i*WB +: WB]                 = '1;
      end else if (IDXW'(i) == idx_q) begin
        beat_data[i*WORD_WIDTH +: WORD_WIDTH] = s_axis.tdata;
        beat_keep[i*WB +: WB]                 = '1;
      end
    end
  end

`ifdef WEIGHTS_PACKER_FRAME_CHECK_EN
  logic err_q;
  logic unused_in;
  assign unused_in   = ^s_axis.tkeep;
  assign err_frame_o = err_q;

  // Sticky frame-length error: tlast must mark exactly the final word.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_q <= 1'b0;
    end else if (cfg_valid_i && state_q == IDLE) begin
      err_q <= 1'b0;
    end else if (s_hs && (s_axis.tlast != last_word)) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_in;
  assign unused_in   = ^{s_axis.tkeep, s_axis.tlast};
  assign err_frame_o = 1'b0;
`endif

  // Frame FSM with packing datapath and registered output beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      k_1_q      <= '0;
      cin_1_q    <= '0;
      bc_1_q     <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tlast_q  <= 1'b0;
      for (int i = 0; i < WPB; i++) buf_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_valid_i) begin
            k_1_q   <= cfg_k_1_i;
            cin_1_q <= cfg_cin_1_i;
            bc_1_q  <= cfg_beats_config_1_i;
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q   <= frame_total(k_1_q, cin_1_q, bc_1_q);
          idx_q   <= '0;
          state_q <= PACK;
        end
        PACK: begin
          if (s_hs) begin
            buf_q[idx_q] <= s_axis.tdata;
            rem_q        <= rem_q - TW'(1);
            idx_q        <= beat_done ? '0 : idx_q + IDXW'(1);
          end
          // A new beat may overwrite one being accepted this cycle: no bubble.
          if (beat_done) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= beat_data;
            m_tkeep_q  <= beat_keep;
            m_tlast_q  <= last_word;
            if (last_word) state_q <= DRAIN;
          end else if (out_hs) begin
            m_tvalid_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_hs) begin
            m_tvalid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_weights_packer.sv
// Scoreboard bench for axis_weights_packer: a frame model derives the
// expected beat list from the config; a monitor pops and compares each
// accepted beat and checks that held beats stay stable.
module tb_axis_weights_packer;
  localparam int WPB = 8;
  localparam int ROW = 12;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_k_1 = '0;
  logic [5:0] cfg_cin_1 = '0;
  logic [7:0] cfg_bc_1 = '0;
  logic       busy;
  logic       err_frame;

  axis_weights_packer_if #(.DATA_W(8))  s_axis ();
  axis_weights_packer_if #(.DATA_W(64)) m_axis ();

  axis_weights_packer dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .cfg_valid_i          (cfg_valid),
    .cfg_ready_o          (cfg_ready),
    .cfg_k_1_i            (cfg_k_1),
    .cfg_cin_1_i          (cfg_cin_1),
    .cfg_beats_config_1_i (cfg_bc_1),
    .s_axis               (s_axis),
    .m_axis               (m_axis),
    .busy_o               (busy),
    .err_frame_o          (err_frame)
  );

  always #5 aclk = ~aclk;

  beat_t      exp_q[$];
  logic [7:0] words[$];
  int         checks = 0;
  int         errors = 0;
  int         beat_idx = 0;
  int         rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Downstream ready: 0 = always ready, 1 = random 50%, 2 = stalled.
  initial begin
    m_axis.tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      case (rdy_mode)
        0:       m_axis.tready = 1'b1;
        1:       m_axis.tready = 1'($urandom_range(0, 1));
        default: m_axis.tready = 1'b0;
      endcase
    end
  end

  // Monitor: compare accepted beats against the scoreboard, check held beats.
  initial begin
    beat_t cur, held, e;
    bit    hold_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        hold_prev = 1'b0;
      end else begin
        cur = {m_axis.tdata, m_axis.tkeep, m_axis.tlast};
        if (hold_prev) begin
          check("hold_tvalid", 64'(m_axis.tvalid), 64'd1);
          if (m_axis.tvalid) begin
            check("hold_tdata", cur.data, held.data);
            check("hold_tkeep_tlast", 64'({cur.keep, cur.last}), 64'({held.keep, held.last}));
          end
        end
        if (m_axis.tvalid && m_axis.tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got tdata 0x%0h with no beat expected", cur.data);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("beat%0d_tdata", beat_idx), cur.data, e.data);
            check($sformatf("beat%0d_tkeep", beat_idx), 64'(cur.keep), 64'(e.keep));
            check($sformatf("beat%0d_tlast", beat_idx), 64'(cur.last), 64'(e.last));
          end
          beat_idx++;
        end
        hold_prev = m_axis.tvalid && !m_axis.tready;
        held      = cur;
      end
    end
  end

  // Reference model: build the frame's words and the expected beat list.
  task automatic model_frame(input int k_1, input int cin_1, input int bc_1,
                             input bit seq, output int total, output int nbeats);
    beat_t e;
    total = WPB + (bc_1 + 1 + (k_1 + 1) * (cin_1 + 1)) * ROW;
    words.delete();
    for (int i = 0; i < total; i++) words.push_back(seq ? 8'(i) : 8'($urandom));
    nbeats = 0;
    for (int s = 0; s < total; s += WPB) begin
      e = '0;
      for (int j = 0; j < WPB; j++) begin
        if (s + j < total) begin
          e.data[j*8 +: 8] = words[s + j];
          e.keep[j]        = 1'b1;
        end
      end
      e.last = (s + WPB >= total);
      exp_q.push_back(e);
      nbeats++;
    end
  endtask

  task automatic send_cfg(input int k_1, input int cin_1, input int bc_1, output int idle_cnt);
    bit hs = 1'b0;
    int cnt = 0;
    cfg_valid = 1'b1;
    cfg_k_1   = 2'(k_1);
    cfg_cin_1 = 6'(cin_1);
    cfg_bc_1  = 8'(bc_1);
    idle_cnt  = 0;
    while (!hs) begin
      @(negedge aclk);
      hs = cfg_ready;
      if (!busy) idle_cnt++;
      @(posedge aclk); #1;
      cnt++;
      if (!hs && cnt > 3000) begin
        $display("FAIL cfg_timeout: cfg_ready never seen, got 0 required 1");
        $fatal(1, "cfg handshake timeout");
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic last, input bit stall);
    bit hs = 1'b0;
    int cnt = 0;
    if (stall) begin
      while ($urandom_range(0, 2) == 0) begin
        s_axis.tvalid = 1'b0;
        @(posedge aclk); #1;
      end
    end
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = w;
    s_axis.tlast  = last;
    while (!hs) begin
      @(negedge aclk);
      hs = s_axis.tready;
      @(posedge aclk); #1;
      cnt++;
      if (!hs && cnt > 3000) begin
        $display("FAIL src_timeout: s_axis_tready never seen, got 0 required 1");
        $fatal(1, "source handshake timeout");
      end
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input int total,
                            input bit stall, input int bad_at);
    for (int i = lo; i < hi; i++)
      send_word(words[i], (i == total - 1) || (i == bad_at), stall);
  endtask

  // Wait for the scoreboard to empty and the block to return to IDLE.
  task automatic wait_done(input string name);
    int cnt = 0;
    bit done = 1'b0;
    while (!done && cnt < 3000) begin
      @(negedge aclk);
      done = (exp_q.size() == 0) && !busy;
      cnt++;
    end
    @(posedge aclk); #1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: %0d beats still expected, busy=%0b, required 0 and 0",
               name, exp_q.size(), busy);
    end
    check({name, "_cfg_ready"}, 64'(cfg_ready), 64'd1);
  endtask

  task automatic run_frame(input string name, input int k_1, input int cin_1, input int bc_1,
                           input bit seq, input bit stall, input int bad_at,
                           output int idle_cnt);
    int total, nbeats, b0;
    b0 = beat_idx;
    model_frame(k_1, cin_1, bc_1, seq, total, nbeats);
    send_cfg(k_1, cin_1, bc_1, idle_cnt);
    send_range(0, total, total, stall, bad_at);
    wait_done(name);
    check({name, "_nbeats"}, 64'(beat_idx - b0), 64'(nbeats));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_cnt, total, nbeats, b0;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tkeep  = '1;
    s_axis.tlast  = 1'b0;

    // Reset state
    #2;
    check("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("rst_tdata", m_axis.tdata, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    check("rst_s_tready", 64'(s_axis.tready), 64'd0);
    check("rst_err", 64'(err_frame), 64'd0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;

    // Case 1: 140 sequential words, 18 beats
    rdy_mode = 0;
    run_frame("case1", 2, 2, 1, 1'b1, 1'b0, -1, idle_cnt);
    check("case1_err", 64'(err_frame), 64'd0);

    // Case 2: minimal frame of 32 words
    run_frame("case2", 0, 0, 0, 1'b0, 1'b0, -1, idle_cnt);

    // Case 3: case 1 with random backpressure and source stalls
    rdy_mode = 1;
    run_frame("case3", 2, 2, 1, 1'b1, 1'b1, -1, idle_cnt);

    // Case 4: case 2 then case 1 back to back
    rdy_mode = 0;
    b0 = beat_idx;
    model_frame(0, 0, 0, 1'b0, total, nbeats);
    send_cfg(0, 0, 0, idle_cnt);
    send_range(0, total, total, 1'b0, -1);
    model_frame(2, 2, 1, 1'b1, total, nbeats);
    send_cfg(2, 2, 1, idle_cnt);
    check("case4_idle_cycles", 64'(idle_cnt), 64'd1);
    send_range(0, total, total, 1'b0, -1);
    wait_done("case4");
    check("case4_nbeats", 64'(beat_idx - b0), 64'd22);

    // Case 5: reset in the middle of case 1, then a clean case 2
    model_frame(2, 2, 1, 1'b1, total, nbeats);
    send_cfg(2, 2, 1, idle_cnt);
    send_range(0, 70, total, 1'b0, -1);
    rdy_mode = 2;
    send_range(70, 72, total, 1'b0, -1);
    @(posedge aclk); #1;
    check("case5_pre_reset_tvalid", 64'(m_axis.tvalid), 64'd1);
    #1 aresetn = 1'b0;
    #1;
    check("case5_reset_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("case5_reset_tkeep", 64'(m_axis.tkeep), 64'd0);
    check("case5_reset_busy", 64'(busy), 64'd0);
    exp_q.delete();
    rdy_mode = 0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    run_frame("case5_after", 0, 0, 0, 1'b0, 1'b0, -1, idle_cnt);

    // Case 6: misplaced source tlast at word 100
    rdy_mode = 1;
    run_frame("case6", 2, 2, 1, 1'b1, 1'b1, 100, idle_cnt);
`ifdef WEIGHTS_PACKER_FRAME_CHECK_EN
    check("case6_err_set", 64'(err_frame), 64'd1);
    repeat (5) @(posedge aclk);
    #1 check("case6_err_held", 64'(err_frame), 64'd1);
    run_frame("case6_clear", 0, 0, 0, 1'b0, 1'b0, -1, idle_cnt);
    check("case6_err_cleared", 64'(err_frame), 64'd0);
`else
    check("case6_err_tied", 64'(err_frame), 64'd0);
`endif

    // Random configs, random data, random backpressure and stalls
    for (int n = 0; n < 3; n++) begin
      run_frame($sformatf("rand%0d", n), $urandom_range(0, 2), $urandom_range(0, 7),
                $urandom_range(0, 3), 1'b0, 1'b1, -1, idle_cnt);
      check($sformatf("rand%0d_err", n), 64'(err_frame), 64'd0);
    end

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
